debouncer_mc: RTL
=================

// Module: debouncer_mc
// PURPOSE
//  Multi-channel switch debouncer: N_CH independent pushbutton/switch inputs.
//  Each channel has a 2FF synchroniser and per-channel pull-up/pull-down polarity.
//  The debounce threshold is programmable at run time.
//  Each channel produces a polarity-normalised debounced level plus one-cycle
//  press, release and long-press event pulses.
//  Sits between board-level switch pins and control/CSR logic.
// PARAMETERS
//  N_CH        4     number of channels (>=1)
//  CNT_W       16    width of debounce counter and of i_thresh
//  PULLUP_MASK '0    N_CH bits; bit c=1 -> channel c is pull-up (idle '1', ON '0')
//  LONG_W      20    width of the long-press hold counter
//  LONG_CYC    2**19 long-press threshold in cycles; 0 disables o_long (tied 0)
// PORTS
//  clk        in   1      clock
//  rstn       in   1      synchronous reset, active-low
//  i_sig      in   N_CH   raw asynchronous switch inputs
//  i_thresh   in   CNT_W  debounce threshold T in cycles, quasi-static; 0 treated as 1
//  o_state    out  N_CH   debounced level, normalised: 1=ON (pressed), 0=OFF
//  o_press    out  N_CH   1-cycle pulse, coincident with o_state rising
//  o_release  out  N_CH   1-cycle pulse, coincident with o_state falling
//  o_long     out  N_CH   1-cycle pulse once per press after LONG_CYC cycles ON
// BEHAVIOUR
//  Reset (rstn=0 at posedge):
//   - sync flops load PULLUP_MASK[c] (idle level); all counters clear to 0.
//   - o_state, o_press, o_release, o_long all 0.
//   - No event pulse is ever generated by entering or leaving reset.
//   - Reset mid-count discards the count; reset while ON forces OFF silently.
//  Normalise: s[c] = sync2[c] ^ PULLUP_MASK[c].
//  Per-channel FSM {ST_OFF, ST_ON}; T_eff = (i_thresh==0) ? 1 : i_thresh.
//   - s == state: cnt <= 0.
//   - s != state and cnt >= T_eff-1: toggle state, cnt <= 0, pulse press/release.
//   - otherwise: cnt <= cnt+1.
//   - Any single-cycle agreement with state restarts the count (glitch reject).
//   - >= (not ==) compare: lowering i_thresh mid-count toggles at the next edge
//     if already past the new threshold; counter never wraps.
//  Latency: if edge k is the first to sample the new i_sig level and the level is
//   held, o_state changes at edge k+1+T_eff. Minimum i_sig->o_state is 2 edges (T=1).
//  Pulses are registered, high exactly 1 cycle; press and release never coincide.
//  Long press:
//   - hold counter clears while OFF; increments while ON, saturating at LONG_CYC.
//   - o_long pulses in the cycle the counter reaches LONG_CYC-1 -> at most 1 per press.
//   - Release before that point: no o_long.
//   - LONG_W must satisfy 2**LONG_W > LONG_CYC (elaboration assertion).
//  Channels are fully independent; simultaneous events on several channels are
//   all reported in the same cycle.
// STRUCTURE
//  debouncer_pkg (shared package):
//   - typedef enum logic {ST_OFF, ST_ON} db_state_e
//   - function t_eff(thresh) implementing the 0->1 clamp
//  debounce_ch sub-module: one channel (sync, FSM, counters, pulses);
//   parameters CNT_W, IS_PULLUP, LONG_W, LONG_CYC.
//  Top instantiates N_CH copies via generate and shares i_thresh across all of them.
// TESTING
//  1 Reset, T=4, ch0 pull-down, i_sig[0] 0->1 held -> o_state[0]=1 and o_press[0]
//    pulse at edge k+5; no other outputs toggle.
//  2 T=8, i_sig[0] toggles every 3 cycles for 40 cycles, then settles at 1 ->
//    no event during bounce; one press 9 edges after the last sampled edge.
//  3 PULLUP_MASK=4'b0010, i_sig=4'b0010 through and after reset -> all outputs 0
//    for 100 cycles; drive i_sig[1]=0 for T cycles -> o_state[1]=1, press[1] pulse.
//  4 LONG_CYC=16, T=2: hold ch2 ON for 40 cycles -> exactly one o_long[2],
//    16 cycles after press; release at 10 cycles ON -> no o_long.
//  5 T=100, after 50 differing cycles set i_thresh=20 -> toggle at next edge;
//    i_thresh=0 -> behaves as T=1.
//  6 All 4 channels pressed same cycle, then rstn pulsed low while ON -> 4
//    simultaneous press pulses; reset clears o_state with no release pulses.

Source files
------------

// File: rtl/debouncer_pkg.sv
// Shared types and helpers for the multi-channel switch debouncer.
package debouncer_pkg;

  // Debounced level of one channel, already polarity-normalised.
  typedef enum logic {
    ST_OFF = 1'b0,
    ST_ON  = 1'b1
  } db_state_e;

  // Widest debounce counter the threshold helper can carry.
  localparam int unsigned MaxCntW = 32;

  localparam logic [MaxCntW-1:0] ThreshOne = {{(MaxCntW-1){1'b0}}, 1'b1};

  // A zero threshold would never let the counter qualify, so treat it as one cycle.
  function automatic logic [MaxCntW-1:0] t_eff(input logic [MaxCntW-1:0] thresh);
    return (thresh == '0) ? ThreshOne : thresh;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debouncer channel: 2FF synchroniser, polarity normalisation, ON/OFF FSM with
// restartable debounce counter, registered press/release pulses and long-press detect.
module debounce_ch
  import debouncer_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter bit          IS_PULLUP = 1'b0,
  parameter int unsigned LONG_W    = 20,
  parameter int unsigned LONG_CYC  = 2**19
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_sig,
  input  logic [CNT_W-1:0] i_thresh,
  output logic             o_state,
  output logic             o_press,
  output logic             o_release,
  output logic             o_long
);

  // Hold counter saturates here; the long pulse fires one value earlier.
  localparam logic [LONG_W-1:0] HoldMax  = LONG_W'(LONG_CYC);
  localparam logic [LONG_W-1:0] HoldFire = LONG_W'(LONG_CYC - 1);
  localparam bit                LongEn   = (LONG_CYC != 0);

  if ((64'(LONG_CYC) >> LONG_W) != 64'd0) begin : g_long_w_check
    $error("debounce_ch: LONG_W too narrow to hold LONG_CYC");
  end

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  db_state_e        state_q, state_d;
  db_state_e        s_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] thresh_m1;
  logic [LONG_W-1:0] hold_q, hold_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;

  // Clamped threshold minus one: the counter value at which a differing level is accepted.
  always_comb begin
    thresh_m1 = CNT_W'(t_eff(MaxCntW'(i_thresh)) - ThreshOne);
  end

  // Synchroniser next state; reset loads the idle level so leaving reset looks like OFF.
  always_comb begin
    sync1_d = i_sig;
    sync2_d = sync1_q;
  end

  // Synchroniser flops.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_q <= IS_PULLUP;
      sync2_q <= IS_PULLUP;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // Debounce FSM: any agreement with the current state restarts the count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    s_state   = ((sync2_q ^ IS_PULLUP) == 1'b1) ? ST_ON : ST_OFF;

    if (s_state == state_q) begin
      cnt_d = '0;
    end else if (cnt_q >= thresh_m1) begin
      // >= lets a lowered threshold take effect immediately and keeps cnt from wrapping.
      cnt_d = '0;
      if (state_q == ST_OFF) begin
        state_d = ST_ON;
        press_d = 1'b1;
      end else begin
        state_d   = ST_OFF;
        release_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Long-press hold counter: saturating at LongCyc makes the fire value unique per press.
  always_comb begin
    hold_d = '0;
    long_d = 1'b0;
    if (state_q == ST_ON) begin
      hold_d = (hold_q != HoldMax) ? hold_q + LONG_W'(1) : hold_q;
      long_d = LongEn && (hold_q == HoldFire);
    end
  end

  // State, counters and registered event pulses.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign o_state   = (state_q == ST_ON);
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;

endmodule

// File: rtl/debouncer_mc.sv
// Multi-channel switch debouncer: N_CH independent channels sharing one run-time threshold.
module debouncer_mc
  import debouncer_pkg::*;
#(
  parameter int unsigned          N_CH        = 4,
  parameter int unsigned          CNT_W       = 16,
  parameter logic [N_CH-1:0]      PULLUP_MASK = '0,
  parameter int unsigned          LONG_W      = 20,
  parameter int unsigned          LONG_CYC    = 2**19
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_CH-1:0]  i_sig,
  input  logic [CNT_W-1:0] i_thresh,
  output logic [N_CH-1:0]  o_state,
  output logic [N_CH-1:0]  o_press,
  output logic [N_CH-1:0]  o_release,
  output logic [N_CH-1:0]  o_long
);

  if (N_CH < 1) begin : g_nch_check
    $error("debouncer_mc: N_CH must be at least 1");
  end

  if (CNT_W < 1 || CNT_W > MaxCntW) begin : g_cntw_check
    $error("debouncer_mc: CNT_W out of supported range");
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    debounce_ch #(
      .CNT_W     (CNT_W),
      .IS_PULLUP (PULLUP_MASK[c]),
      .LONG_W    (LONG_W),
      .LONG_CYC  (LONG_CYC)
    ) u_ch (
      .clk       (clk),
      .rstn      (rstn),
      .i_sig     (i_sig[c]),
      .i_thresh  (i_thresh),
      .o_state   (o_state[c]),
      .o_press   (o_press[c]),
      .o_release (o_release[c]),
      .o_long    (o_long[c])
    );
  end

endmodule
